// File: rtl/csr_trap_seq.sv
// -----------------------------------------------------------------------------
// csr_trap_seq
//
// Purpose:
//   Initiator side of the CSR read/write port. In IDLE, pipeline CSR accesses
//   pass straight through to the CSR register file. When a trap entry or an
//   mret request is accepted, the sequencer takes ownership of the port. It
//   runs a fixed sequence of CSR reads and writes (mstatus, mepc, mcause,
//   mtval, mtvec), then emits a one-cycle PC redirect to fetch.
//
// Optional feature (compile-time macro):
//   CSR_TRAP_VECTORED_EN - if defined, an interrupt with mtvec[1:0]==2'b01
//                          redirects to base + (cause << 2). If undefined,
//                          the redirect always goes to the mtvec base.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   trap_valid_i/ready_o      request handshake (accepted on valid & ready)
//   trap_mret_i               1 = mret, 0 = trap entry
//   trap_is_irq_i             interrupt flag (mcause MSB)
//   trap_cause_i              exception/interrupt code
//   trap_pc_i, trap_tval_i    values for mepc and mtval
//   busy_o                    sequencer owns the CSR port
//   redirect_valid_o/pc_o     one-cycle PC redirect pulse and target
//   pipe_*                    pipeline-side CSR access
//   csr_*                     CSR register file access
// -----------------------------------------------------------------------------
module csr_trap_seq #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      trap_valid_i,
    output logic                      trap_ready_o,
    input  logic                      trap_mret_i,
    input  logic                      trap_is_irq_i,
    input  logic [4:0]                trap_cause_i,
    input  logic [DATA_WIDTH-1:0]     trap_pc_i,
    input  logic [DATA_WIDTH-1:0]     trap_tval_i,
    output logic                      busy_o,
    output logic                      redirect_valid_o,
    output logic [DATA_WIDTH-1:0]     redirect_pc_o,
    input  logic [CSR_ADDR_WIDTH-1:0] pipe_raddr_i,
    output logic [DATA_WIDTH-1:0]     pipe_rdata_o,
    input  logic                      pipe_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] pipe_waddr_i,
    input  logic [DATA_WIDTH-1:0]     pipe_wdata_i,
    output logic [CSR_ADDR_WIDTH-1:0] csr_raddr_o,
    input  logic [DATA_WIDTH-1:0]     csr_rdata_i,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o
);

    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVEC   = CSR_ADDR_WIDTH'(12'h305);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVAL   = CSR_ADDR_WIDTH'(12'h343);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RD_STATUS = 4'd1,
        S_WR_STATUS = 4'd2,
        S_WR_EPC    = 4'd3,
        S_WR_CAUSE  = 4'd4,
        S_WR_TVAL   = 4'd5,
        S_RD_TVEC   = 4'd6,
        S_RD_EPC    = 4'd7,
        S_REDIRECT  = 4'd8
    } state_e;

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode, other bits kept.
    function automatic logic [DATA_WIDTH-1:0] trap_status(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mret: MIE <= MPIE, MPIE <= 1, MPP <= M-mode, other bits kept.
    function automatic logic [DATA_WIDTH-1:0] mret_status(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mcause layout: interrupt flag in the MSB, code in the low bits.
    function automatic logic [DATA_WIDTH-1:0] mcause_value(input logic irq, input logic [4:0] cause);
        logic [DATA_WIDTH-1:0] r;
        r                 = '0;
        r[DATA_WIDTH-1]   = irq;
        r[4:0]            = cause;
        return r;
    endfunction

    state_e                  state_q, state_d;
    logic                    busy_q;
    logic                    redirect_valid_q;
    logic [DATA_WIDTH-1:0]   redirect_pc_q;
    logic                    mret_q;
    logic                    irq_q;
    logic [4:0]              cause_q;
    logic [DATA_WIDTH-3:0]   epc_q;     // word-aligned PC, low bits are always zero in mepc
    logic [DATA_WIDTH-1:0]   tval_q;
    logic [DATA_WIDTH-1:0]   status_q;
    logic                    accept_s;
    logic [DATA_WIDTH-1:0]   redir_base_s;
    logic [DATA_WIDTH-1:0]   redir_pc_s;

    assign accept_s     = (state_q == S_IDLE) && trap_valid_i;
    assign trap_ready_o = (state_q == S_IDLE) && !rst_i;
    assign busy_o           = busy_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;

    // Next-state selection; mret branches off after the mstatus update.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (trap_valid_i) begin
                    state_d = S_RD_STATUS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_STATUS: state_d = S_WR_STATUS;
            S_WR_STATUS: state_d = mret_q ? S_RD_EPC : S_WR_EPC;
            S_WR_EPC:    state_d = S_WR_CAUSE;
            S_WR_CAUSE:  state_d = S_WR_TVAL;
            S_WR_TVAL:   state_d = S_RD_TVEC;
            S_RD_TVEC:   state_d = S_REDIRECT;
            S_RD_EPC:    state_d = S_REDIRECT;
            S_REDIRECT:  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Redirect target, evaluated while mtvec or mepc is on the read port.
    always_comb begin
        redir_base_s = {csr_rdata_i[DATA_WIDTH-1:2], 2'b00};
`ifdef CSR_TRAP_VECTORED_EN
        if (!mret_q && irq_q && (csr_rdata_i[1:0] == 2'b01)) begin
            redir_pc_s = redir_base_s + {{(DATA_WIDTH-7){1'b0}}, cause_q, 2'b00};
        end else begin
            redir_pc_s = redir_base_s;
        end
`else
        redir_pc_s = redir_base_s;
`endif
    end

    // Sequencer state, request capture and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            busy_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mret_q           <= 1'b0;
            irq_q            <= 1'b0;
            cause_q          <= 5'd0;
            epc_q            <= '0;
            tval_q           <= '0;
            status_q         <= '0;
        end else begin
            state_q          <= state_d;
            busy_q           <= (state_d != S_IDLE);
            redirect_valid_q <= (state_d == S_REDIRECT);
            if (accept_s) begin
                mret_q  <= trap_mret_i;
                irq_q   <= trap_is_irq_i;
                cause_q <= trap_cause_i;
                epc_q   <= trap_pc_i[DATA_WIDTH-1:2];
                tval_q  <= trap_tval_i;
            end
            // Read data is only ever registered here, never fed back into a
            // same-cycle write, so the file's write-forward path stays acyclic.
            if (state_q == S_RD_STATUS) begin
                status_q <= csr_rdata_i;
            end
            if (state_d == S_REDIRECT) begin
                redirect_pc_q <= redir_pc_s;
            end
        end
    end

    // CSR port mux: pipeline passthrough in IDLE, sequencer accesses otherwise.
    // Writes are gated by reset so an aborted sequence stops writing at once.
    always_comb begin
        csr_raddr_o  = '0;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        pipe_rdata_o = '0;
        case (state_q)
            S_IDLE: begin
                csr_raddr_o  = pipe_raddr_i;
                csr_we_o     = pipe_we_i && !rst_i;
                csr_waddr_o  = pipe_waddr_i;
                csr_wdata_o  = pipe_wdata_i;
                pipe_rdata_o = csr_rdata_i;
            end
            S_RD_STATUS: begin
                csr_raddr_o = ADDR_MSTATUS;
            end
            S_WR_STATUS: begin
                csr_we_o    = !rst_i;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = mret_q ? mret_status(status_q) : trap_status(status_q);
            end
            S_WR_EPC: begin
                csr_we_o    = !rst_i;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = {epc_q, 2'b00};
            end
            S_WR_CAUSE: begin
                csr_we_o    = !rst_i;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = mcause_value(irq_q, cause_q);
            end
            S_WR_TVAL: begin
                csr_we_o    = !rst_i;
                csr_waddr_o = ADDR_MTVAL;
                csr_wdata_o = tval_q;
            end
            S_RD_TVEC: begin
                csr_raddr_o = ADDR_MTVEC;
            end
            S_RD_EPC: begin
                csr_raddr_o = ADDR_MEPC;
            end
            S_REDIRECT: begin
                csr_raddr_o = '0;
            end
            default: begin
                csr_raddr_o = '0;
            end
        endcase
    end

endmodule

// File: doc/csr_trap_seq.md
Name: csr_trap_seq

Overview:
- Initiator side of the CSR read/write port: issues CSR accesses to the CSR register file.
- In idle, passes pipeline CSR accesses straight through.
- On a trap request (exception/interrupt) or mret, takes ownership of the port. Runs a fixed multi-cycle sequence of CSR reads and writes (mstatus, mepc, mcause, mtval, mtvec).
- Then emits a one-cycle PC redirect to the fetch stage.

Parameters:
DATA_WIDTH, 32, CSR data width.
CSR_ADDR_WIDTH, 12, CSR address width.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
trap_valid_i  in  1  trap/mret request valid
trap_ready_o  out  1  request accepted when valid&ready
trap_mret_i  in  1  1 = mret request, 0 = trap entry
trap_is_irq_i  in  1  trap is an interrupt (mcause[31])
trap_cause_i  in  5  exception/interrupt code
trap_pc_i  in  DATA_WIDTH  PC of trapping instruction
trap_tval_i  in  DATA_WIDTH  value for mtval
busy_o  out  1  sequencer owns CSR port; pipeline must stall CSR ops
redirect_valid_o  out  1  one-cycle pulse, PC redirect
redirect_pc_o  out  DATA_WIDTH  redirect target
pipe_raddr_i  in  CSR_ADDR_WIDTH  pipeline CSR read address
pipe_rdata_o  out  DATA_WIDTH  pipeline CSR read data
pipe_we_i  in  1  pipeline CSR write enable
pipe_waddr_i  in  CSR_ADDR_WIDTH  pipeline CSR write address
pipe_wdata_i  in  DATA_WIDTH  pipeline CSR write data
csr_raddr_o  out  CSR_ADDR_WIDTH  to CSR file read address
csr_rdata_i  in  DATA_WIDTH  CSR file read data (combinational, forwards same-cycle write)
csr_we_o  out  1  to CSR file write enable
csr_waddr_o  out  CSR_ADDR_WIDTH  to CSR file write address
csr_wdata_o  out  DATA_WIDTH  to CSR file write data

Behaviour:
- Reset: state IDLE; trap_ready_o=0 during reset; busy_o, redirect_valid_o, csr_we_o = 0; redirect_pc_o = 0; capture registers = 0. Reset mid-sequence aborts immediately: no further CSR writes, no redirect.
- IDLE:
  - trap_ready_o=1, busy_o=0.
  - csr_* mirror pipe_* combinationally; pipe_rdata_o = csr_rdata_i.
  - On valid&ready, register mret/irq/cause/pc/tval and go to RD_STATUS. The pipeline write in the accept cycle still passes through.
- Busy states:
  - busy_o=1, trap_ready_o=0, pipe_we_i ignored, pipe_rdata_o=0.
  - Reads are sampled into a register, never written back in the same cycle. This avoids the combinational loop through the CSR file write-forward path.
- Trap sequence, one cycle each:
  - RD_STATUS: raddr=mstatus; capture.
  - WR_STATUS: write mstatus with MPIE[7]<=MIE[3], MIE[3]<=0, MPP[12:11]<=2'b11; other bits preserved.
  - WR_EPC: mepc <= {pc[31:2],2'b00}.
  - WR_CAUSE: mcause <= {irq, 26'b0, cause}.
  - WR_TVAL: mtval <= tval.
  - RD_TVEC: raddr=mtvec; capture.
  - REDIRECT: redirect_valid_o=1, pc={mtvec[31:2],2'b00}.
  - Then IDLE.
  - Latency: redirect in the 7th cycle after the accept edge.
- Mret sequence:
  - RD_STATUS.
  - WR_STATUS: MIE<=MPIE, MPIE<=1, MPP<=2'b11.
  - RD_EPC: capture mepc.
  - REDIRECT: pc={mepc[31:2],2'b00}.
  - Then IDLE. Redirect in the 4th cycle.
- csr_we_o is high only in WR_* states, and for exactly one cycle per CSR.
- redirect_pc_o holds its last value outside REDIRECT.
- A new request may be accepted in the cycle after REDIRECT (back-to-back, no bubble beyond IDLE).
- trap_mret_i is ignored unless trap_valid_i=1.

Optional Feature:
CSR_TRAP_VECTORED_EN:
- Defined: in REDIRECT for a trap with irq=1 and mtvec[1:0]==2'b01, pc = {mtvec[31:2],2'b00} + (cause<<2). Exceptions and mode 2'b00 use the base.
- Undefined: always base, mtvec[1:0] ignored.

Test Plan:
1. Pipeline passthrough: idle, pipe_we_i=1, waddr=0x340, wdata=0xA5A5_0000 -> csr_we_o=1 same cycle, same addr/data; pipe_raddr_i=0x305 -> csr_raddr_o=0x305, pipe_rdata_o=csr_rdata_i.
2. Exception entry: mstatus=0x0000_0008, mtvec=0x8000_0100; request irq=0, cause=2, pc=0x8000_0046, tval=0xDEAD_BEEF ->
   - writes in order: mstatus=0x0000_1880, mepc=0x8000_0044, mcause=0x0000_0002, mtval=0xDEAD_BEEF;
   - redirect pulse with pc 0x8000_0100 in the 7th cycle.
3. Mret: mstatus=0x0000_1880, mepc=0x8000_0044 -> mstatus write 0x0000_1888; redirect 0x8000_0044 in the 4th cycle; busy_o high for 4 cycles.
4. Stall/ignore: pipe_we_i=1 to 0x340 during trap sequence -> no csr write to 0x340; trap_ready_o=0; second trap_valid_i held is accepted the cycle after REDIRECT.
5. Reset mid-op: assert rst_i during WR_CAUSE -> next cycle csr_we_o=0, busy_o=0, no redirect; mtval never written.
6. Vectored, with the macro defined: mtvec=0x8000_0101, irq=1, cause=7 -> redirect 0x8000_011C. Without the macro -> 0x8000_0100.
